// File: rtl/ahb_sram_swc.sv
// AHB-Lite single-beat SRAM slave with a configurable number of wait states.
// Out-of-range, oversize or misaligned transfers get a two-cycle ERROR response.
module ahb_sram_swc #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter logic [31:0] MEM_BASE    = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        hclk,
    input  logic        hrstn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [1:0]  htrans,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata
);

    localparam int unsigned WORDS    = 2 ** (ADDR_WIDTH - 2);
    localparam int unsigned IDX_W    = ADDR_WIDTH - 2;
    localparam bit          HAS_WAIT = (WAIT_STATES != 0);
    localparam logic [3:0]  WS_LOAD  = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DONE = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            2'd0:    m = 4'b0001 << off;
            2'd1:    m = off[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = m[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return r;
    endfunction

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    write_q;
    logic [31:0]             hrdata_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [1:0]              size_q;
    logic [31:0]             mem_q [WORDS];

    logic                    addr_hit, size_ok, align_ok, legal;
    logic                    can_accept, accept;
    logic                    commit, rd_new, ld_rd;
    logic [IDX_W-1:0]        lat_idx, rd_idx;
    logic [3:0]              wr_mask;
    logic [31:0]             rd_word;
    logic                    unused_htrans;

    assign unused_htrans = htrans[0];

    always_comb begin
        addr_hit = (haddr[31:ADDR_WIDTH] == MEM_BASE[31:ADDR_WIDTH]);
        size_ok  = (hsize <= 3'd2);
        case (hsize)
            3'd1:    align_ok = ~haddr[0];
            3'd2:    align_ok = (haddr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
        legal = addr_hit & size_ok & align_ok;
    end

    // A new address is only taken while the slave is not stalling the bus.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hreadyout  = 1'b1;
        hresp      = 1'b0;
        can_accept = 1'b0;
        case (state_q)
            S_IDLE: can_accept = 1'b1;
            S_WAIT: begin
                hreadyout = 1'b0;
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                can_accept = 1'b1;
                state_d    = S_IDLE;
            end
            S_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                state_d   = S_ERR2;
            end
            S_ERR2: begin
                hresp      = 1'b1;
                can_accept = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        accept = can_accept & hsel & hready & htrans[1];
        if (accept) begin
            if (!legal) begin
                state_d = S_ERR1;
            end else if (HAS_WAIT) begin
                state_d = S_WAIT;
                cnt_d   = WS_LOAD;
            end else begin
                state_d = S_DONE;
            end
        end
    end

    // Read data is captured on the edge entering DONE; with no wait states that
    // edge can coincide with the commit of the previous write, which is forwarded.
    always_comb begin
        commit  = (state_q == S_DONE) & write_q;
        lat_idx = addr_q[ADDR_WIDTH-1:2];
        wr_mask = lane_mask(size_q, addr_q[1:0]);
        rd_new  = accept & legal & ~HAS_WAIT & ~hwrite;
        ld_rd   = rd_new | ((state_q == S_WAIT) & (cnt_q == 4'd0) & ~write_q);
        rd_idx  = rd_new ? haddr[ADDR_WIDTH-1:2] : lat_idx;
        rd_word = merge_lanes(mem_q[rd_idx], hwdata,
                              (commit && (lat_idx == rd_idx)) ? wr_mask : 4'b0000);
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            write_q  <= 1'b0;
            hrdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                write_q <= hwrite;
            end
            if (ld_rd) begin
                hrdata_q <= rd_word;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (accept) begin
            addr_q <= haddr[ADDR_WIDTH-1:0];
            size_q <= hsize[1:0];
        end
        if (commit) begin
            mem_q[lat_idx] <= merge_lanes(mem_q[lat_idx], hwdata, wr_mask);
        end
    end

    assign hrdata = hrdata_q;

endmodule

// File: tb/tb_ahb_sram_swc.sv
// Scoreboard bench for ahb_sram_swc: three instances with 1, 0 and 3 wait states,
// each driven by its own bus; a monitor checks every data phase against a queue.
module tb_ahb_sram_swc;

    typedef struct {
        bit          rd;
        logic [31:0] data;
        bit          resp;
        int          waits;
        string       name;
    } exp_t;

    logic        hclk;
    logic [2:0]  hrstn, hsel, hwrite, hready, hreadyout, hresp, hrdy_en;
    logic [31:0] haddr  [3];
    logic [2:0]  hsize  [3];
    logic [1:0]  htrans [3];
    logic [31:0] hwdata [3];
    logic [31:0] hrdata [3];

    exp_t sb_q [3][$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   in_dp  [3];
    int   lowc   [3];
    bit   lowbad [3];

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign hready[g] = hrdy_en[g] & hreadyout[g];
        ahb_sram_swc #(
            .ADDR_WIDTH (12),
            .MEM_BASE   (32'h0000_0000),
            .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .hclk     (hclk),
            .hrstn    (hrstn[g]),
            .hsel     (hsel[g]),
            .haddr    (haddr[g]),
            .hwrite   (hwrite[g]),
            .hsize    (hsize[g]),
            .htrans   (htrans[g]),
            .hwdata   (hwdata[g]),
            .hready   (hready[g]),
            .hreadyout(hreadyout[g]),
            .hresp    (hresp[g]),
            .hrdata   (hrdata[g])
        );
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    function automatic exp_t mk_exp(input int k, input bit wr, input logic [31:0] rexp,
                                    input bit err, input string nm);
        exp_t e;
        e.rd    = !wr;
        e.data  = rexp;
        e.resp  = err;
        e.waits = err ? 1 : ws_of(k);
        e.name  = nm;
        return e;
    endfunction

    // Single transfer: address phase, then data phase until hreadyout completes it.
    task automatic xfer(input int k, input logic [31:0] a, input bit wr, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [31:0] rexp, input bit err,
                        input string nm);
        int n;
        sb_q[k].push_back(mk_exp(k, wr, rexp, err, nm));
        hsel[k]   = 1'b1;
        haddr[k]  = a;
        hwrite[k] = wr;
        hsize[k]  = sz;
        htrans[k] = 2'b10;
        @(posedge hclk); #1;
        hsel[k]   = 1'b0;
        htrans[k] = 2'b00;
        hwdata[k] = wd;
        n = 0;
        while (!hreadyout[k] && n < 40) begin
            @(posedge hclk); #1;
            n++;
        end
        n_tests++;
        if (n >= 40) begin
            n_fail++;
            $display("FAIL %s timeout: hreadyout %b, required 1", nm, hreadyout[k]);
        end
        @(posedge hclk); #1;
    endtask

    initial begin : monitor
        bit done;
        exp_t e;
        forever begin
            @(negedge hclk);
            for (int k = 0; k < 3; k++) begin
                done = 1'b0;
                if (!hrstn[k]) begin
                    sb_q[k].delete();
                    in_dp[k] = 1'b0;
                end else begin
                    if (in_dp[k]) begin
                        if (!hreadyout[k]) begin
                            lowc[k]++;
                            if (sb_q[k].size() > 0 && hresp[k] !== sb_q[k][0].resp) lowbad[k] = 1'b1;
                        end else begin
                            done = 1'b1;
                            n_tests++;
                            if (sb_q[k].size() == 0) begin
                                n_fail++;
                                $display("FAIL dut%0d completion: got unexpected data phase, required none", k);
                            end else begin
                                e = sb_q[k].pop_front();
                                chk($sformatf("dut%0d %s waits", k, e.name), lowc[k], e.waits);
                                chk($sformatf("dut%0d %s hresp", k, e.name), hresp[k], e.resp);
                                chk($sformatf("dut%0d %s hresp in wait", k, e.name), lowbad[k], 0);
                                if (e.rd && !e.resp)
                                    chk($sformatf("dut%0d %s hrdata", k, e.name), hrdata[k], e.data);
                            end
                        end
                    end else begin
                        chk($sformatf("dut%0d idle {hreadyout,hresp}", k), {hreadyout[k], hresp[k]}, 2'b10);
                    end
                    if (!in_dp[k] || done) begin
                        in_dp[k]  = hsel[k] & hready[k] & htrans[k][1];
                        lowc[k]   = 0;
                        lowbad[k] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        hsel    = '0;
        hwrite  = '0;
        hrdy_en = '1;
        hrstn   = '1;
        for (int k = 0; k < 3; k++) begin
            haddr[k]  = '0;
            hsize[k]  = '0;
            htrans[k] = '0;
            hwdata[k] = '0;
            in_dp[k]  = 1'b0;
            lowc[k]   = 0;
            lowbad[k] = 1'b0;
        end
        #2 hrstn = '0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("dut%0d reset hreadyout", k), hreadyout[k], 1);
            chk($sformatf("dut%0d reset hresp", k), hresp[k], 0);
            chk($sformatf("dut%0d reset hrdata", k), hrdata[k], 0);
        end
        repeat (2) @(posedge hclk);
        #1 hrstn = '1;
        @(posedge hclk); #1;

        // one wait state: word, byte lane, errors, ignored phases
        xfer(0, 32'h010, 1, 3'd2, 32'hDEAD_BEEF, 32'h0, 0, "wr 0x010");
        xfer(0, 32'h010, 0, 3'd2, 32'h0, 32'hDEAD_BEEF, 0, "rd 0x010");
        xfer(0, 32'h020, 1, 3'd2, 32'h1122_3344, 32'h0, 0, "wr 0x020");
        xfer(0, 32'h022, 1, 3'd0, 32'h00AB_0000, 32'h0, 0, "wrb 0x022");
        xfer(0, 32'h020, 0, 3'd2, 32'h0, 32'h11AB_3344, 0, "rd 0x020");
        xfer(0, 32'h030, 1, 3'd2, 32'h5566_7788, 32'h0, 0, "wr 0x030");
        xfer(0, 32'h031, 1, 3'd1, 32'hFFFF_FFFF, 32'h0, 1, "wrh 0x031 misaligned");
        xfer(0, 32'h032, 1, 3'd2, 32'hFFFF_FFFF, 32'h0, 1, "wr 0x032 misaligned");
        xfer(0, 32'h030, 0, 3'd2, 32'h0, 32'h5566_7788, 0, "rd 0x030 unchanged");
        xfer(0, 32'h1000, 0, 3'd2, 32'h0, 32'h0, 1, "rd 0x1000 range");
        xfer(0, 32'h000, 0, 3'd3, 32'h0, 32'h0, 1, "rd hsize3");
        xfer(0, 32'h050, 1, 3'd2, 32'h1234_5678, 32'h0, 0, "wr 0x050");
        hwdata[0] = 32'hFFFF_FFFF;
        for (int p = 0; p < 4; p++) begin
            hsel[0]    = (p != 2);
            haddr[0]   = 32'h050;
            hwrite[0]  = 1'b1;
            hsize[0]   = 3'd2;
            htrans[0]  = (p == 0) ? 2'b00 : ((p == 1) ? 2'b01 : 2'b10);
            hrdy_en[0] = (p != 3);
            @(posedge hclk); #1;
        end
        hsel[0]    = 1'b0;
        htrans[0]  = 2'b00;
        hrdy_en[0] = 1'b1;
        @(posedge hclk); #1;
        xfer(0, 32'h050, 0, 3'd2, 32'h0, 32'h1234_5678, 0, "rd 0x050 after ignored");

        // zero wait states: read accepted in the write's completion cycle
        xfer(1, 32'h040, 1, 3'd2, 32'h0, 32'h0, 0, "wr 0x040 clear");
        sb_q[1].push_back(mk_exp(1, 1, 32'h0, 0, "wr 0x040 fwd"));
        hsel[1] = 1'b1; haddr[1] = 32'h040; hwrite[1] = 1'b1; hsize[1] = 3'd2; htrans[1] = 2'b10;
        @(posedge hclk); #1;
        hwdata[1] = 32'hCAFE_F00D;
        hwrite[1] = 1'b0;
        sb_q[1].push_back(mk_exp(1, 0, 32'hCAFE_F00D, 0, "rd 0x040 fwd"));
        @(posedge hclk); #1;
        hsel[1] = 1'b0; htrans[1] = 2'b00;
        @(posedge hclk); #1;
        xfer(1, 32'h040, 0, 3'd2, 32'h0, 32'hCAFE_F00D, 0, "rd 0x040");
        xfer(1, 32'h042, 1, 3'd1, 32'hBEEF_0000, 32'h0, 0, "wrh 0x042");
        xfer(1, 32'h040, 0, 3'd2, 32'h0, 32'hBEEF_F00D, 0, "rd 0x040 half");

        // three wait states: error length, reset during a write's wait phase
        xfer(2, 32'h060, 1, 3'd2, 32'hA5A5_A5A5, 32'h0, 0, "wr 0x060");
        xfer(2, 32'h060, 0, 3'd2, 32'h0, 32'hA5A5_A5A5, 0, "rd 0x060");
        xfer(2, 32'h004, 0, 3'd3, 32'h0, 32'h0, 1, "rd hsize3 ws3");
        hsel[2] = 1'b1; haddr[2] = 32'h060; hwrite[2] = 1'b1; hsize[2] = 3'd2; htrans[2] = 2'b10;
        @(posedge hclk); #1;
        hsel[2] = 1'b0; htrans[2] = 2'b00; hwdata[2] = 32'h5A5A_5A5A;
        @(negedge hclk); #2;
        chk("dut2 pre-reset hreadyout", hreadyout[2], 0);
        hrstn[2] = 1'b0;
        #1;
        chk("dut2 async reset hreadyout", hreadyout[2], 1);
        chk("dut2 async reset hresp", hresp[2], 0);
        chk("dut2 async reset hrdata", hrdata[2], 0);
        @(posedge hclk);
        @(posedge hclk); #1;
        hrstn[2] = 1'b1;
        @(posedge hclk); #1;
        xfer(2, 32'h060, 0, 3'd2, 32'h0, 32'hA5A5_A5A5, 0, "rd 0x060 after reset");

        repeat (3) @(posedge hclk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("dut%0d scoreboard drained", k), sb_q[k].size(), 0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
